// File: rtl/gif_frame_loader.sv
// Byte-stream loader for the GIF frame store: sync/header parse, 3-byte pixel packing, frame memory write strobes.
// Optional trailing XOR checksum byte per frame when GIF_LOADER_CHECKSUM_EN is defined.
module gif_frame_loader #(
  parameter int unsigned NUM_FRAMES       = 4,
  parameter int unsigned FRAME_BITS       = 2,
  parameter int unsigned ADDR_WIDTH       = 11,
  parameter int unsigned PIXELS_PER_FRAME = 2048,
  parameter logic [7:0]  SYNC_BYTE        = 8'hA5,
  parameter int unsigned TIMEOUT          = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [FRAME_BITS-1:0] wr_frame,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [23:0]           wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PIX,
    S_WR,
    S_DONE
`ifdef GIF_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [15:0]           pix_q, pix_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  in_ready_q, in_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [FRAME_BITS-1:0] wr_frame_q, wr_frame_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]           wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_q, err_d;
`ifdef GIF_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic accept;
  logic hdr_ok;
  logic timed_out;
  logic waiting;
  logic last_word;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      pix_q        <= '0;
      timer_q      <= '0;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_frame_q   <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef GIF_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      pix_q        <= pix_d;
      timer_q      <= timer_d;
      in_ready_q   <= in_ready_d;
      wr_en_q      <= wr_en_d;
      wr_frame_q   <= wr_frame_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
`ifdef GIF_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pix_d      = pix_q;
    wr_frame_d = wr_frame_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = 1'b0;
`ifdef GIF_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    accept    = in_valid & in_ready_q;
    hdr_ok    = (in_data[7:FRAME_BITS] == '0) &&
                (32'(in_data[FRAME_BITS-1:0]) < NUM_FRAMES);
    timed_out = (timer_q == TIMER_W'(TIMEOUT - 1));
    last_word = (wr_addr_q == ADDR_WIDTH'(PIXELS_PER_FRAME - 1));
    waiting   = (state_q == S_HDR) || (state_q == S_PIX);
`ifdef GIF_LOADER_CHECKSUM_EN
    waiting   = waiting || (state_q == S_CHK);
`endif

    // Idle-cycle watchdog while waiting on bytes inside a frame.
    if (waiting && !accept && !timed_out) timer_d = timer_q + TIMER_W'(1);
    else                                  timer_d = '0;

    case (state_q)
      S_IDLE: begin
        if (accept && (in_data == SYNC_BYTE)) state_d = S_HDR;
      end
      S_HDR: begin
        if (accept) begin
          if (hdr_ok) begin
            wr_frame_d = in_data[FRAME_BITS-1:0];
            wr_addr_d  = '0;
            byte_cnt_d = '0;
`ifdef GIF_LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
            state_d    = S_PIX;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_PIX: begin
        if (accept) begin
`ifdef GIF_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (byte_cnt_q == 2'd2) begin
            wr_data_d  = {pix_q, in_data};
            byte_cnt_d = '0;
            state_d    = S_WR;
          end else begin
            pix_d      = {pix_q[7:0], in_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (timed_out) begin
          err_d      = 1'b1;
          byte_cnt_d = '0;
          state_d    = S_IDLE;
        end
      end
      S_WR: begin
        if (last_word) begin
`ifdef GIF_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
          state_d   = S_PIX;
        end
      end
`ifdef GIF_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    in_ready_d   = (state_d != S_WR) && (state_d != S_DONE);
    wr_en_d      = (state_d == S_WR);
    frame_done_d = (state_d == S_DONE);
    busy_d       = (state_d == S_PIX) || (state_d == S_WR);
`ifdef GIF_LOADER_CHECKSUM_EN
    busy_d       = busy_d || (state_d == S_CHK);
`endif
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_frame   = wr_frame_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule
